// File: rtl/hood_mode_ctrl.sv
// Range-hood mode controller: turns panel button edges into operating state,
// fan level and the hurricane/cooldown countdown.
//
// state    | meaning
// ---------+----------------------------------------------
// OFF      | powered down, outputs idle
// STANDBY  | powered, fan stopped
// MENU     | level selection pending
// LV1/LV2  | steady fan level 1 / 2
// LV3      | hurricane, timed, falls back to LV2
// COOLDOWN | timed exit from LV3 at full fan, then STANDBY
module hood_mode_ctrl #(
   parameter int TICK_CYCLES   = 100_000_000,
   parameter int HURRICANE_SEC = 60,
   parameter int COOLDOWN_SEC  = 60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       on_off_btn,
   input  logic       menu_btn,
   input  logic       mode1_btn,
   input  logic       mode2_btn,
   input  logic       mode3_btn,
   output logic [2:0] state,
   output logic [1:0] fan_level,
   output logic [6:0] sec_left,
   output logic       hurricane_used
);

   localparam int             CW         = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [CW-1:0]  TICK_LAST  = CW'(TICK_CYCLES - 1);
   localparam logic [6:0]     HURR_LOAD  = 7'(HURRICANE_SEC);
   localparam logic [6:0]     COOL_LOAD  = 7'(COOLDOWN_SEC);

   typedef enum logic [2:0] {
      ST_OFF      = 3'd0,
      ST_STANDBY  = 3'd1,
      ST_MENU     = 3'd2,
      ST_LV1      = 3'd3,
      ST_LV2      = 3'd4,
      ST_LV3      = 3'd5,
      ST_COOLDOWN = 3'd6
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    fan_q, fan_d;
   logic [6:0]    sec_q, sec_d;
   logic          hu_q, hu_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [4:0]    btn, btn_q;
   logic          armed_q;
   logic [4:0]    edge_w, pick;
   logic          tick;

   // bit 4 = power (highest priority) down to bit 0 = mode3
   assign btn    = {on_off_btn, menu_btn, mode1_btn, mode2_btn, mode3_btn};
   // armed_q masks the first cycle after reset so a held button is not an edge
   assign edge_w = btn & ~btn_q & {5{armed_q}};
   assign tick   = (cnt_q == TICK_LAST);

   always_comb begin
      pick    = '0;
      pick[4] = edge_w[4];
      pick[3] = edge_w[3] & ~edge_w[4];
      pick[2] = edge_w[2] & ~|edge_w[4:3];
      pick[1] = edge_w[1] & ~|edge_w[4:2];
      pick[0] = edge_w[0] & ~|edge_w[4:1];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_OFF;
         fan_q   <= 2'd0;
         sec_q   <= 7'd0;
         hu_q    <= 1'b0;
         cnt_q   <= '0;
         btn_q   <= '0;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         fan_q   <= fan_d;
         sec_q   <= sec_d;
         hu_q    <= hu_d;
         cnt_q   <= cnt_d;
         btn_q   <= btn;
         armed_q <= 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      sec_d   = sec_q;
      hu_d    = hu_q;
      cnt_d   = tick ? '0 : cnt_q + 1'b1;
      if (state_q != ST_OFF && pick[4]) begin
         state_d = ST_OFF;
         sec_d   = 7'd0;
         hu_d    = 1'b0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_OFF: begin
               if (pick[4]) state_d = ST_STANDBY;
            end
            ST_STANDBY: begin
               if (pick[3]) state_d = ST_MENU;
            end
            ST_MENU: begin
               if (pick[3])      state_d = ST_STANDBY;
               else if (pick[2]) state_d = ST_LV1;
               else if (pick[1]) state_d = ST_LV2;
               else if (pick[0] && !hu_q) begin
                  state_d = ST_LV3;
                  hu_d    = 1'b1;
                  sec_d   = HURR_LOAD;
                  cnt_d   = '0;
               end
            end
            ST_LV1, ST_LV2: begin
               if (pick[3])      state_d = ST_STANDBY;
               else if (pick[2]) state_d = ST_LV1;
               else if (pick[1]) state_d = ST_LV2;
            end
            ST_LV3: begin
               if (pick[3]) begin
                  state_d = ST_COOLDOWN;
                  sec_d   = COOL_LOAD;
                  cnt_d   = '0;
               end else if (tick && sec_q != 7'd0) begin
                  sec_d = sec_q - 7'd1;
                  if (sec_q == 7'd1) state_d = ST_LV2;
               end
            end
            ST_COOLDOWN: begin
               if (tick && sec_q != 7'd0) begin
                  sec_d = sec_q - 7'd1;
                  if (sec_q == 7'd1) state_d = ST_STANDBY;
               end
            end
            default: begin
               state_d = ST_OFF;
               sec_d   = 7'd0;
               hu_d    = 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      fan_d = 2'd0;
      case (state_d)
         ST_LV1:                  fan_d = 2'd1;
         ST_LV2:                  fan_d = 2'd2;
         ST_LV3, ST_COOLDOWN:     fan_d = 2'd3;
         default:                 fan_d = 2'd0;
      endcase
   end

   assign state          = state_q;
   assign fan_level      = fan_q;
   assign sec_left       = sec_q;
   assign hurricane_used = hu_q;

endmodule

// File: tb/tb_hood_mode_ctrl.sv
// Directed scenario tasks plus a randomized run against a cycle-budget model
// of the hood controller (timers tracked as remaining clock cycles).
module tb_hood_mode_ctrl;
   localparam int TC = 4;
   localparam int HS = 3;
   localparam int CS = 2;
   localparam logic [4:0] PWR  = 5'b10000;
   localparam logic [4:0] MENU = 5'b01000;
   localparam logic [4:0] M1   = 5'b00100;
   localparam logic [4:0] M2   = 5'b00010;
   localparam logic [4:0] M3   = 5'b00001;
   localparam logic [4:0] NONE = 5'b00000;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] b;
   logic [2:0] state;
   logic [1:0] fan_level;
   logic [6:0] sec_left;
   logic       hurricane_used;

   int n_vec = 0;
   int n_err = 0;

   int         m_state, m_rem;
   bit         m_hu, m_armed;
   logic [4:0] m_prev;

   always #5 clk = ~clk;

   hood_mode_ctrl #(.TICK_CYCLES(TC), .HURRICANE_SEC(HS), .COOLDOWN_SEC(CS)) dut (
      .clk            (clk),
      .rst            (rst),
      .on_off_btn     (b[4]),
      .menu_btn       (b[3]),
      .mode1_btn      (b[2]),
      .mode2_btn      (b[1]),
      .mode3_btn      (b[0]),
      .state          (state),
      .fan_level      (fan_level),
      .sec_left       (sec_left),
      .hurricane_used (hurricane_used)
   );

   task automatic cyc(input logic [4:0] v);
      b = v;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      b = NONE;
      rst = 1'b0;
      #2;
      rst = 1'b1;
      cyc(NONE);
   endtask

   task automatic test_reset();
      b = PWR;
      rst = 1'b1;
      #1;
      rst = 1'b0;
      #2;
      n_vec++; if (state !== 3'd0) begin n_err++; $display("FAIL reset_state got=%0d exp=0", state); end
      n_vec++; if (fan_level !== 2'd0) begin n_err++; $display("FAIL reset_fan got=%0d exp=0", fan_level); end
      n_vec++; if (sec_left !== 7'd0) begin n_err++; $display("FAIL reset_sec got=%0d exp=0", sec_left); end
      n_vec++; if (hurricane_used !== 1'b0) begin n_err++; $display("FAIL reset_hu got=%0d exp=0", hurricane_used); end
      rst = 1'b1;
      cyc(PWR);
      cyc(PWR);
      n_vec++; if (state !== 3'd0) begin n_err++; $display("FAIL held_pwr_no_edge got=%0d exp=0", state); end
      cyc(NONE);
      cyc(PWR);
      n_vec++; if (state !== 3'd1) begin n_err++; $display("FAIL pwr_on_state got=%0d exp=1", state); end
      n_vec++; if (fan_level !== 2'd0) begin n_err++; $display("FAIL pwr_on_fan got=%0d exp=0", fan_level); end
      cyc(PWR);
      n_vec++; if (state !== 3'd1) begin n_err++; $display("FAIL pwr_held_level got=%0d exp=1", state); end
      cyc(NONE);
      cyc(PWR);
      n_vec++; if (state !== 3'd0) begin n_err++; $display("FAIL pwr_off_state got=%0d exp=0", state); end
      cyc(NONE);
   endtask

   task automatic test_levels();
      do_reset();
      cyc(PWR); cyc(NONE);
      cyc(M1);
      n_vec++; if (state !== 3'd1) begin n_err++; $display("FAIL standby_ignores_mode got=%0d exp=1", state); end
      cyc(NONE); cyc(MENU); cyc(NONE);
      cyc(M2);
      n_vec++; if (state !== 3'd4) begin n_err++; $display("FAIL lvl2_state got=%0d exp=4", state); end
      n_vec++; if (fan_level !== 2'd2) begin n_err++; $display("FAIL lvl2_fan got=%0d exp=2", fan_level); end
      cyc(NONE);
      cyc(M1);
      n_vec++; if (state !== 3'd3) begin n_err++; $display("FAIL lvl1_state got=%0d exp=3", state); end
      n_vec++; if (fan_level !== 2'd1) begin n_err++; $display("FAIL lvl1_fan got=%0d exp=1", fan_level); end
      cyc(NONE);
      cyc(M3);
      n_vec++; if (state !== 3'd3) begin n_err++; $display("FAIL lvl1_ignores_m3 got=%0d exp=3", state); end
      cyc(NONE);
      cyc(MENU);
      n_vec++; if (state !== 3'd1) begin n_err++; $display("FAIL lvl_menu_state got=%0d exp=1", state); end
      n_vec++; if (fan_level !== 2'd0) begin n_err++; $display("FAIL lvl_menu_fan got=%0d exp=0", fan_level); end
      cyc(NONE);
   endtask

   task automatic test_hurricane();
      do_reset();
      cyc(PWR); cyc(NONE); cyc(MENU); cyc(NONE);
      cyc(M3);
      n_vec++; if (state !== 3'd5) begin n_err++; $display("FAIL lv3_state got=%0d exp=5", state); end
      n_vec++; if (fan_level !== 2'd3) begin n_err++; $display("FAIL lv3_fan got=%0d exp=3", fan_level); end
      n_vec++; if (sec_left !== 7'd3) begin n_err++; $display("FAIL lv3_sec got=%0d exp=3", sec_left); end
      n_vec++; if (hurricane_used !== 1'b1) begin n_err++; $display("FAIL lv3_hu got=%0d exp=1", hurricane_used); end
      repeat (3) cyc(NONE);
      n_vec++; if (sec_left !== 7'd3) begin n_err++; $display("FAIL lv3_sec_c3 got=%0d exp=3", sec_left); end
      cyc(NONE);
      n_vec++; if (sec_left !== 7'd2) begin n_err++; $display("FAIL lv3_sec_c4 got=%0d exp=2", sec_left); end
      repeat (7) cyc(NONE);
      n_vec++; if (state !== 3'd5 || sec_left !== 7'd1) begin n_err++; $display("FAIL lv3_c11 got=%0d/%0d exp=5/1", state, sec_left); end
      cyc(NONE);
      n_vec++; if (state !== 3'd4) begin n_err++; $display("FAIL fallback_state got=%0d exp=4", state); end
      n_vec++; if (fan_level !== 2'd2) begin n_err++; $display("FAIL fallback_fan got=%0d exp=2", fan_level); end
      n_vec++; if (sec_left !== 7'd0) begin n_err++; $display("FAIL fallback_sec got=%0d exp=0", sec_left); end
      cyc(MENU);
      n_vec++; if (state !== 3'd1) begin n_err++; $display("FAIL oneshot_standby got=%0d exp=1", state); end
      cyc(NONE); cyc(MENU); cyc(NONE);
      cyc(M3);
      n_vec++; if (state !== 3'd2) begin n_err++; $display("FAIL oneshot_blocked got=%0d exp=2", state); end
      n_vec++; if (hurricane_used !== 1'b1) begin n_err++; $display("FAIL oneshot_hu got=%0d exp=1", hurricane_used); end
      cyc(NONE);
      cyc(PWR);
      n_vec++; if (hurricane_used !== 1'b0) begin n_err++; $display("FAIL off_clears_hu got=%0d exp=0", hurricane_used); end
      cyc(NONE); cyc(PWR); cyc(NONE); cyc(MENU); cyc(NONE);
      cyc(M3);
      n_vec++; if (state !== 3'd5) begin n_err++; $display("FAIL oneshot_rearm got=%0d exp=5", state); end
      cyc(NONE);
   endtask

   task automatic test_cooldown();
      do_reset();
      cyc(PWR); cyc(NONE); cyc(MENU); cyc(NONE); cyc(M3);
      cyc(MENU);
      n_vec++; if (state !== 3'd6) begin n_err++; $display("FAIL cd_state got=%0d exp=6", state); end
      n_vec++; if (fan_level !== 2'd3) begin n_err++; $display("FAIL cd_fan got=%0d exp=3", fan_level); end
      n_vec++; if (sec_left !== 7'd2) begin n_err++; $display("FAIL cd_sec got=%0d exp=2", sec_left); end
      cyc(M1);
      n_vec++; if (state !== 3'd6) begin n_err++; $display("FAIL cd_ignores_m1 got=%0d exp=6", state); end
      cyc(NONE); cyc(MENU);
      n_vec++; if (state !== 3'd6 || sec_left !== 7'd2) begin n_err++; $display("FAIL cd_c3 got=%0d/%0d exp=6/2", state, sec_left); end
      cyc(NONE);
      n_vec++; if (sec_left !== 7'd1) begin n_err++; $display("FAIL cd_c4 got=%0d exp=1", sec_left); end
      repeat (3) cyc(NONE);
      n_vec++; if (state !== 3'd6) begin n_err++; $display("FAIL cd_c7 got=%0d exp=6", state); end
      cyc(NONE);
      n_vec++; if (state !== 3'd1 || fan_level !== 2'd0 || sec_left !== 7'd0) begin n_err++; $display("FAIL cd_exit got=%0d/%0d/%0d exp=1/0/0", state, fan_level, sec_left); end
   endtask

   task automatic test_collision();
      do_reset();
      cyc(PWR); cyc(NONE);
      cyc(MENU | M1);
      n_vec++; if (state !== 3'd2) begin n_err++; $display("FAIL menu_beats_m1 got=%0d exp=2", state); end
      cyc(NONE);
      cyc(M3);
      repeat (11) cyc(NONE);
      cyc(PWR);
      n_vec++; if (state !== 3'd0 || sec_left !== 7'd0) begin n_err++; $display("FAIL pwr_beats_tick got=%0d/%0d exp=0/0", state, sec_left); end
      n_vec++; if (fan_level !== 2'd0 || hurricane_used !== 1'b0) begin n_err++; $display("FAIL pwr_beats_tick_out got=%0d/%0d exp=0/0", fan_level, hurricane_used); end
      cyc(NONE); cyc(PWR); cyc(NONE); cyc(MENU); cyc(NONE); cyc(M3);
      repeat (3) cyc(NONE);
      cyc(MENU);
      n_vec++; if (state !== 3'd6 || sec_left !== 7'd2) begin n_err++; $display("FAIL menu_beats_tick got=%0d/%0d exp=6/2", state, sec_left); end
      repeat (3) cyc(NONE);
      n_vec++; if (sec_left !== 7'd2) begin n_err++; $display("FAIL cd_full_second got=%0d exp=2", sec_left); end
      cyc(NONE);
      n_vec++; if (sec_left !== 7'd1) begin n_err++; $display("FAIL cd_first_tick got=%0d exp=1", sec_left); end
      rst = 1'b0;
      #2;
      n_vec++; if (state !== 3'd0 || fan_level !== 2'd0 || sec_left !== 7'd0 || hurricane_used !== 1'b0)
         begin n_err++; $display("FAIL async_rst got=%0d/%0d/%0d/%0d exp=0/0/0/0", state, fan_level, sec_left, hurricane_used); end
      rst = 1'b1;
      cyc(NONE); cyc(NONE);
      n_vec++; if (state !== 3'd0) begin n_err++; $display("FAIL stays_off got=%0d exp=0", state); end
   endtask

   function automatic void model_reset();
      m_state = 0; m_rem = 0; m_hu = 0; m_armed = 0; m_prev = '0;
   endfunction

   function automatic void model_step(input logic [4:0] v);
      logic [4:0] e;
      int top, old, nxt;
      e = m_armed ? (v & ~m_prev) : 5'b0;
      m_prev = v;
      m_armed = 1;
      top = -1;
      for (int i = 0; i < 5; i++) if (e[i]) top = i;
      old = m_state;
      nxt = old;
      if (top == 4) nxt = (old == 0) ? 1 : 0;
      else begin
         case (old)
            1: if (top == 3) nxt = 2;
            2: begin
               if (top == 3) nxt = 1;
               else if (top == 2) nxt = 3;
               else if (top == 1) nxt = 4;
               else if (top == 0 && !m_hu) begin nxt = 5; m_hu = 1; m_rem = HS * TC; end
            end
            3, 4: begin
               if (top == 3) nxt = 1;
               else if (top == 2) nxt = 3;
               else if (top == 1) nxt = 4;
            end
            5: if (top == 3) begin nxt = 6; m_rem = CS * TC; end
            default: ;
         endcase
      end
      if (nxt == 0) begin m_hu = 0; m_rem = 0; end
      if (nxt == old && (old == 5 || old == 6)) begin
         m_rem--;
         if (m_rem == 0) nxt = (old == 5) ? 4 : 1;
      end
      m_state = nxt;
   endfunction

   task automatic test_random();
      logic [4:0] v;
      int exp_sec, exp_fan;
      do_reset();
      model_reset();
      model_step(NONE);
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 199) == 0) begin
            rst = 1'b0;
            #2;
            n_vec++; if (state !== 3'd0 || fan_level !== 2'd0 || sec_left !== 7'd0 || hurricane_used !== 1'b0)
               begin n_err++; $display("FAIL rnd_rst n=%0d got=%0d/%0d/%0d/%0d exp=0/0/0/0", n, state, fan_level, sec_left, hurricane_used); end
            rst = 1'b1;
            model_reset();
         end
         v[4] = ($urandom_range(0, 29) == 0);
         for (int k = 0; k < 4; k++) v[k] = ($urandom_range(0, 2) == 0);
         cyc(v);
         model_step(v);
         exp_sec = (m_state == 5 || m_state == 6) ? (m_rem + TC - 1) / TC : 0;
         case (m_state)
            3: exp_fan = 1;
            4: exp_fan = 2;
            5, 6: exp_fan = 3;
            default: exp_fan = 0;
         endcase
         n_vec++; if (state !== 3'(m_state)) begin n_err++; $display("FAIL rnd_state n=%0d got=%0d exp=%0d", n, state, m_state); end
         n_vec++; if (fan_level !== 2'(exp_fan)) begin n_err++; $display("FAIL rnd_fan n=%0d got=%0d exp=%0d", n, fan_level, exp_fan); end
         n_vec++; if (sec_left !== 7'(exp_sec)) begin n_err++; $display("FAIL rnd_sec n=%0d got=%0d exp=%0d", n, sec_left, exp_sec); end
         n_vec++; if (hurricane_used !== m_hu) begin n_err++; $display("FAIL rnd_hu n=%0d got=%0d exp=%0d", n, hurricane_used, m_hu); end
      end
   endtask

   initial begin
      b = NONE;
      test_reset();
      test_levels();
      test_hurricane();
      test_cooldown();
      test_collision();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/hood_mode_ctrl.md
# hood_mode_ctrl

Mode controller for the range-hood: converts the front-panel buttons into a registered operating state, fan level and countdown. It enforces the power, menu, and level-1/2/3 sequencing rules. It also enforces the timed "hurricane" (level 3) rules: auto-fallback, one use per power-on, and a timed exit cooldown. It sits between the panel inputs and the display/fan datapath, and drives their mode selection.

## Interface

Parameters:
- TICK_CYCLES, 100_000_000: clock cycles per 1 s tick.
- HURRICANE_SEC, 60: level-3 duration before auto-fallback, in seconds, 1..127.
- COOLDOWN_SEC, 60: exit delay after leaving level 3 via menu, in seconds, 1..127.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- on_off_btn  in  1  power button, synchronized level.
- menu_btn  in  1  menu button, synchronized level.
- mode1_btn  in  1  level-1 button, synchronized level.
- mode2_btn  in  1  level-2 button, synchronized level.
- mode3_btn  in  1  level-3 (hurricane) button, synchronized level.
- state  out  3  OFF=0, STANDBY=1, MENU=2, LV1=3, LV2=4, LV3=5, COOLDOWN=6.
- fan_level  out  2  0 = stopped, otherwise 1/2/3.
- sec_left  out  7  remaining seconds in LV3/COOLDOWN; 0 elsewhere.
- hurricane_used  out  1  level 3 already entered since power-on.

## Operation

- Each button gets a 1-bit registered copy. An edge is `btn & ~btn_q`. Only edges act; held levels do nothing.
- Priority when edges coincide: power > menu > mode1 > mode2 > mode3. Only the highest-priority edge is acted on in that cycle.
- Power edge:
  - OFF → STANDBY.
  - Any other state → OFF immediately. This applies in LV3 and COOLDOWN too.
  - Entering OFF clears hurricane_used, sec_left and the tick counter.
- STANDBY: menu → MENU. Mode edges are ignored.
- MENU:
  - mode1 → LV1.
  - mode2 → LV2.
  - mode3 → LV3 only if hurricane_used=0; otherwise it is ignored.
  - menu → STANDBY.
- LV1/LV2:
  - mode1 → LV1 and mode2 → LV2 (direct switch).
  - mode3 is ignored.
  - menu → STANDBY.
- LV3:
  - On entry, set hurricane_used=1 and load sec_left=HURRICANE_SEC.
  - sec_left decrements each tick. A tick moving it from 1 to 0 transitions to LV2.
  - menu → COOLDOWN and loads sec_left=COOLDOWN_SEC.
  - mode edges are ignored.
- COOLDOWN:
  - sec_left decrements each tick. Expiry (1 to 0) → STANDBY.
  - menu and mode edges are ignored. Only power exits early.
- fan_level by state: OFF/STANDBY/MENU → 0; LV1 → 1; LV2 → 2; LV3 → 3; COOLDOWN → 3.
- Tick counter:
  - Counts 0..TICK_CYCLES-1 and emits a tick when it wraps.
  - Cleared to 0 on every entry to LV3 or COOLDOWN, so the first second is full length.
  - Free-running elsewhere; its value is don't-care.
- Width rule: the counter is sized by $clog2(TICK_CYCLES). sec_left never underflows and is held at 0 outside the timed states.

## Timing

- Reset (rst=0, async): state=OFF, fan_level=0, sec_left=0, hurricane_used=0, all btn_q=0. All outputs are registered.
- Button latency: the input rises before edge N, and the new state/fan_level/sec_left are visible after edge N (one cycle).
- A button already high when rst releases does not produce an edge.
- LV3 lasts exactly HURRICANE_SEC×TICK_CYCLES cycles from the entry edge to the LV2 edge. COOLDOWN lasts exactly COOLDOWN_SEC×TICK_CYCLES cycles.
- Tick coincident with a menu edge in LV3: the menu edge wins, giving COOLDOWN with a freshly loaded sec_left.
- Tick coincident with a power edge: the power edge wins, giving OFF.
- Reset asserted mid-countdown: immediate OFF with all outputs at their reset values. After release, the unit needs a power edge to restart.

## Test plan

Bench parameters: TICK_CYCLES=4, HURRICANE_SEC=3, COOLDOWN_SEC=2.

- Reset and power-up: reset, then on_off pulse → state=1, fan_level=0. Second on_off pulse → state=0.
- Level selection: power, menu, mode2 → state=4, fan=2. Then mode1 → state=3, fan=1. Then menu → state=1, fan=0.
- Hurricane fallback: power, menu, mode3 → state=5, fan=3, sec_left=3, hurricane_used=1. After exactly 12 cycles → state=4, fan=2, sec_left=0.
- One-shot hurricane: after the fallback, menu (→1), menu (→2), mode3 → state stays 2. Power off/on, then menu, mode3 → state=5.
- Cooldown: in LV3, menu → state=6, fan=3, sec_left=2. A mode1 edge during cooldown is ignored. After 8 cycles → state=1, fan=0.
- Priority/collision:
  - menu+mode1 edges in the same cycle in STANDBY → state=2.
  - Power edge coincident with the LV3 expiry tick → state=0, sec_left=0.
  - rst asserted during COOLDOWN → all outputs 0 asynchronously.
